// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions.
// Holds XLEN and the M-extension operation encodings.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam int MULDIV_CYCLES = XLEN;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } muldiv_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and
// restoring divide on magnitudes, with shared final sign correction.
module muldiv_unit #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   import riscv_pkg::*;

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e            state_q;
   state_e            state_d;
   muldiv_op_e        op_in;
   muldiv_op_e        op_q;
   logic [CW-1:0]     cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_d;
   logic [XLEN-1:0]   bmag_q;
   logic [XLEN-1:0]   result_q;
   logic              neg_a_q;
   logic              neg_b_q;

   logic            sgn_a;
   logic            sgn_b;
   logic            neg_a;
   logic            neg_b;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] spec_res;
   logic            last;

   assign op_in = muldiv_op_e'(op_i);

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (op_in)
         MD_MULH, MD_DIV, MD_REM: begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         MD_MULHSU: sgn_a = 1'b1;
         default: ;
      endcase
   end

   assign neg_a = sgn_a & op_a_i[XLEN-1];
   assign neg_b = sgn_b & op_b_i[XLEN-1];
   assign a_mag = neg_a ? (~op_a_i + 1'b1) : op_a_i;
   assign b_mag = neg_b ? (~op_b_i + 1'b1) : op_b_i;

   // Corner cases resolve at accept and skip the iterative phase
   assign div_zero = op_i[2] && (op_b_i == '0);
   assign div_ovf  = sgn_a && op_i[2]
                   && (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (op_b_i == '1);
   assign special  = div_zero | div_ovf;

   always_comb begin
      spec_res = '0;
      if (div_zero)
         spec_res = op_i[1] ? op_a_i : '1;
      else if (div_ovf)
         spec_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_sh;
   logic            rem_ge;
   logic [XLEN-1:0] rem_new;

   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, bmag_q} : '0);
   assign rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_ge  = rem_sh >= {1'b0, bmag_q};
   assign rem_new = rem_ge ? (rem_sh[XLEN-1:0] - bmag_q)
                           : rem_sh[XLEN-1:0];

   always_comb begin
      if (op_q[2])
         acc_d = {rem_new, acc_q[XLEN-2:0], rem_ge};
      else
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
   end

   logic [2*XLEN-1:0] fix_in;
   logic [2*XLEN-1:0] fixed;
   logic              fix_neg;
   logic [XLEN-1:0]   res_fix;

   always_comb begin
      fix_in  = acc_d;
      fix_neg = neg_a_q ^ neg_b_q;
      if (op_q[2]) begin
         if (op_q[1]) begin
            fix_in  = {{XLEN{1'b0}}, acc_d[2*XLEN-1:XLEN]};
            fix_neg = neg_a_q;
         end else begin
            fix_in  = {{XLEN{1'b0}}, acc_d[XLEN-1:0]};
         end
      end
   end

   assign fixed   = fix_neg ? (~fix_in + 1'b1) : fix_in;
   assign res_fix = (op_q == MD_MUL || op_q[2])
                  ? fixed[XLEN-1:0]
                  : fixed[2*XLEN-1:XLEN];

   assign last = (cnt_q == CW'(XLEN - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = special ? DONE : CALC;
         CALC: if (last) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         op_q     <= MD_MUL;
         cnt_q    <= '0;
         acc_q    <= '0;
         bmag_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) begin
               op_q    <= op_in;
               cnt_q   <= '0;
               acc_q   <= {{XLEN{1'b0}}, a_mag};
               bmag_q  <= b_mag;
               neg_a_q <= neg_a;
               neg_b_q <= neg_b;
               if (special)
                  result_q <= spec_res;
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (last)
                  result_q <= res_fix;
            end
            default: ;
         endcase
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an
// arithmetic reference model.
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   muldiv_unit dut (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .op_a_i   (op_a_i),
      .op_b_i   (op_b_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_acc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] ref_model(
      input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] as_, au, bs, bu, p;
      int          sa, sb;
      logic [31:0] r;
      as_ = {{32{a[31]}}, a};
      au  = {32'd0, a};
      bs  = {{32{b[31]}}, b};
      bu  = {32'd0, b};
      sa  = a;
      sb  = b;
      r   = '0;
      case (op)
         3'd0: begin p = au * bu; r = p[31:0]; end
         3'd1: begin p = as_ * bs; r = p[63:32]; end
         3'd2: begin p = as_ * bu; r = p[63:32]; end
         3'd3: begin p = au * bu; r = p[63:32]; end
         3'd4:
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = sa / sb;
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6:
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
            else r = sa % sb;
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_special(
      input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return op[2] && (b == 0 ||
         (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest accepted op
   always @(negedge clk_i) begin
      if (rstn_i && done_o) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_done: done_o at cycle %0d, none expected",
                     cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (result_o !== e.res || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL result op=%0d a=%h b=%h: got %h @%0d expected %h @%0d",
                        e.op, e.a, e.b, result_o, cyc, e.res, e.cyc);
            end
         end
      end
   end

   task automatic drive(input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk_i);
      start_i = st;
      op_i    = op;
      op_a_i  = a;
      op_b_i  = b;
      if (st && rstn_i && !busy_o) begin
         e.res = ref_model(op, a, b);
         e.cyc = cyc + 1 + (is_special(op, a, b) ? 0 : 32);
         e.op  = op;
         e.a   = a;
         e.b   = b;
         q.push_back(e);
         n_acc++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy_o) && n < 200) begin
         drive(1'b0, $urandom_range(7), $urandom, $urandom);
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: pending=%0d busy=%0b, required 0/0",
                  q.size(), busy_o);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      drive(1'b1, op, a, b);
      drain();
   endtask

   initial begin
      int acc0;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      #12;
      check("reset_busy", {31'd0, busy_o}, 32'd0);
      check("reset_done", {31'd0, done_o}, 32'd0);
      check("reset_result", result_o, 32'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;

      drive(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      check("busy_after_accept", {31'd0, busy_o}, 32'd1);
      drain();

      issue(3'd1, 32'h8000_0000, 32'h8000_0000);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2);
      issue(3'd5, 32'd100, 32'd7);
      issue(3'd7, 32'd100, 32'd7);
      issue(3'd5, 32'd5, 32'd0);
      issue(3'd6, 32'd5, 32'd0);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      acc0 = n_acc;
      for (int i = 0; i < 40; i++)
         drive(1'b1, 3'd0, $urandom, $urandom);
      check("held_start_accepts", n_acc - acc0, 32'd2);
      drain();

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(7))
            0: rb = 0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(15);
            default: ;
         endcase
         issue(rop, ra, rb);
      end

      drive(1'b1, 3'd0, 32'h1234_5678, 32'h0000_0FFF);
      repeat (10) drive(1'b0, 3'd0, 32'd0, 32'd0);
      #2;
      rstn_i = 1'b0;
      #1;
      check("midop_reset_busy", {31'd0, busy_o}, 32'd0);
      check("midop_reset_done", {31'd0, done_o}, 32'd0);
      check("midop_reset_result", result_o, 32'd0);
      q.delete();
      @(negedge clk_i);
      #2;
      rstn_i = 1'b1;
      repeat (40) drive(1'b0, 3'd0, 32'd0, 32'd0);
      issue(3'd5, 32'd9, 32'd3);

      check("pending_at_end", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
